// File: rtl/chess_pkg.sv
// ============================================================================
// Module   : chess_pkg
// Desc     : Piece codes, colour classification, standard layout, FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package chess_pkg;

    localparam logic [3:0] PC_EMPTY    = 4'h0;
    localparam logic [3:0] PC_W_PAWN   = 4'h1;
    localparam logic [3:0] PC_W_BISHOP = 4'h2;
    localparam logic [3:0] PC_W_KNIGHT = 4'h3;
    localparam logic [3:0] PC_W_ROOK   = 4'h4;
    localparam logic [3:0] PC_W_QUEEN  = 4'h5;
    localparam logic [3:0] PC_W_KING   = 4'h6;
    localparam logic [3:0] PC_B_PAWN   = 4'h7;
    localparam logic [3:0] PC_B_BISHOP = 4'h8;
    localparam logic [3:0] PC_B_KNIGHT = 4'h9;
    localparam logic [3:0] PC_B_ROOK   = 4'hA;
    localparam logic [3:0] PC_B_QUEEN  = 4'hB;
    localparam logic [3:0] PC_B_KING   = 4'hC;

    // Indexed [row][col]; row 0 is black's back rank.
    localparam logic [0:7][0:7][3:0] STD_LAYOUT = {
        PC_B_ROOK, PC_B_KNIGHT, PC_B_BISHOP, PC_B_QUEEN,
        PC_B_KING, PC_B_BISHOP, PC_B_KNIGHT, PC_B_ROOK,
        {8{PC_B_PAWN}},
        {32{PC_EMPTY}},
        {8{PC_W_PAWN}},
        PC_W_ROOK, PC_W_KNIGHT, PC_W_BISHOP, PC_W_QUEEN,
        PC_W_KING, PC_W_BISHOP, PC_W_KNIGHT, PC_W_ROOK
    };

    typedef enum logic [1:0] {
        CLR_EMPTY   = 2'd0,
        CLR_WHITE   = 2'd1,
        CLR_BLACK   = 2'd2,
        CLR_NEUTRAL = 2'd3
    } colour_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_e;

    function automatic colour_e colour_of(input int unsigned code);
        if (code == 0)       return CLR_EMPTY;
        else if (code <= 6)  return CLR_WHITE;
        else if (code <= 12) return CLR_BLACK;
        return CLR_NEUTRAL;
    endfunction

    function automatic colour_e side_colour(input logic side);
        return side ? CLR_BLACK : CLR_WHITE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/chess_move_check.sv
// ============================================================================
// Module   : chess_move_check
// Desc     : Combinational pick/place legality from square colour and mask.
// Revision : 1.0
// ============================================================================
`default_nettype none

module chess_move_check
    import chess_pkg::*;
#(
    parameter int CODE_W = 4
) (
    input  logic              side,
    input  logic              sel_valid,
    input  logic [CODE_W-1:0] sel_code,
    input  logic              sel_mask,
    output logic              pick_ok,
    output logic              place_ok
);

    colour_e sel_colour;
    colour_e own_colour;

    assign sel_colour = colour_of(32'(sel_code));
    assign own_colour = side_colour(side);

    // Neutral and empty squares are never pickable but may be landed on.
    assign pick_ok  = sel_valid && (sel_colour == own_colour);
    assign place_ok = sel_valid && sel_mask && (sel_colour != own_colour);

endmodule

`default_nettype wire

// File: rtl/chess_board_state.sv
// ============================================================================
// Module   : chess_board_state
// Desc     : Pick/place board state machine with display read port.
//            Optional one-level undo enabled by BOARD_UNDO_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module chess_board_state
    import chess_pkg::*;
#(
    parameter int                ROWS        = 8,
    parameter int                COLS        = 8,
    parameter int                CODE_W      = 4,
    parameter logic [CODE_W-1:0] HILITE_CODE = CODE_W'(4'hD),
    localparam int               RW          = $clog2(ROWS),
    localparam int               CW          = $clog2(COLS),
    localparam int               POS_W       = RW + CW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pick_req,
    input  logic                 place_req,
    input  logic                 cancel_req,
    input  logic                 undo_req,
    input  logic [POS_W-1:0]     sel_pos,
    input  logic [POS_W-1:0]     rd_pos,
    input  logic [ROWS*COLS-1:0] legal_mask,
    output logic [CODE_W-1:0]    board [ROWS][COLS],
    output logic [CODE_W-1:0]    rd_code,
    output logic                 holding,
    output logic [CODE_W-1:0]    held_code,
    output logic [POS_W-1:0]     held_pos,
    output logic                 move_done,
    output logic [CODE_W-1:0]    captured_code,
    output logic                 illegal,
    output logic [15:0]          move_count,
    output logic                 side,
    output logic                 undo_ok
);

    logic [CODE_W-1:0] board_q  [ROWS][COLS];
    logic [CODE_W-1:0] board_d  [ROWS][COLS];
    logic [CODE_W-1:0] board_rv [ROWS][COLS];
    logic              mask_rc  [ROWS][COLS];

    state_e            state_q, state_d;
    logic [CODE_W-1:0] held_code_q, held_code_d;
    logic [POS_W-1:0]  held_pos_q, held_pos_d;
    logic [CODE_W-1:0] captured_q, captured_d;
    logic [15:0]       move_count_q, move_count_d;
    logic              side_q, side_d;
    logic              move_done_q, move_done_d;
    logic              illegal_q, illegal_d;
    logic [CODE_W-1:0] rd_code_q, rd_code_d;

    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            for (genvar c = 0; c < COLS; c++) begin : g_col
                assign mask_rc[r][c]  = legal_mask[ROWS*COLS-1-(r*COLS+c)];
                assign board_rv[r][c] = (ROWS == 8 && COLS == 8) ?
                                        CODE_W'(STD_LAYOUT[r][c]) : '0;
            end
        end
    endgenerate

    logic [RW-1:0]     sel_row, rd_row, held_row;
    logic [CW-1:0]     sel_col, rd_col, held_col;
    logic              sel_valid, rd_valid, sel_mask;
    logic [CODE_W-1:0] sel_code;

    assign sel_row  = sel_pos[POS_W-1:CW];
    assign sel_col  = sel_pos[CW-1:0];
    assign rd_row   = rd_pos[POS_W-1:CW];
    assign rd_col   = rd_pos[CW-1:0];
    assign held_row = held_pos_q[POS_W-1:CW];
    assign held_col = held_pos_q[CW-1:0];

    assign sel_valid = (int'(sel_row) < ROWS) && (int'(sel_col) < COLS);
    assign rd_valid  = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);
    assign sel_code  = sel_valid ? board_q[sel_row][sel_col] : '0;
    assign sel_mask  = sel_valid && mask_rc[sel_row][sel_col];

    logic pick_ok, place_ok;

    chess_move_check #(
        .CODE_W   (CODE_W)
    ) u_move_check (
        .side      (side_q),
        .sel_valid (sel_valid),
        .sel_code  (sel_code),
        .sel_mask  (sel_mask),
        .pick_ok   (pick_ok),
        .place_ok  (place_ok)
    );

    logic is_idle, is_held;
    logic pick_go, pick_bad, cancel_go, commit_go, place_bad, undo_bad;
    logic place_away;

    assign is_idle    = (state_q == ST_IDLE);
    assign is_held    = (state_q == ST_HELD);
    assign pick_go    = is_idle && pick_req && pick_ok;
    assign pick_bad   = is_idle && pick_req && !pick_ok;
    // Dropping back on the origin square behaves exactly like cancel.
    assign cancel_go  = is_held && (cancel_req || (place_req && sel_pos == held_pos_q));
    assign place_away = is_held && !cancel_req && place_req && (sel_pos != held_pos_q);
    assign commit_go  = place_away && place_ok;
    assign place_bad  = place_away && !place_ok;

`ifdef BOARD_UNDO_EN
    logic [POS_W-1:0]  undo_from_q, undo_from_d, undo_to_q, undo_to_d;
    logic [CODE_W-1:0] undo_moved_q, undo_moved_d, undo_cap_q, undo_cap_d;
    logic              undo_ok_q, undo_ok_d;
    logic              undo_go;

    assign undo_go  = is_idle && !pick_req && undo_req && undo_ok_q;
    assign undo_bad = undo_req && (is_held || (!pick_req && !undo_ok_q));
    assign undo_ok  = undo_ok_q;
`else
    logic unused_undo;
    assign unused_undo = undo_req;
    assign undo_bad    = 1'b0;
    assign undo_ok     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_go) state_d = ST_HELD;
            ST_HELD: if (cancel_go || commit_go) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        holding = (state_q == ST_HELD);
    end

    always_comb begin
        board_d      = board_q;
        held_code_d  = held_code_q;
        held_pos_d   = held_pos_q;
        captured_d   = captured_q;
        move_count_d = move_count_q;
        side_d       = side_q;
        move_done_d  = 1'b0;
        illegal_d    = pick_bad || place_bad || undo_bad;
`ifdef BOARD_UNDO_EN
        undo_from_d  = undo_from_q;
        undo_to_d    = undo_to_q;
        undo_moved_d = undo_moved_q;
        undo_cap_d   = undo_cap_q;
        undo_ok_d    = undo_ok_q;
`endif
        if (pick_go) begin
            board_d[sel_row][sel_col] = '0;
            held_code_d = sel_code;
            held_pos_d  = sel_pos;
        end
        if (cancel_go) begin
            board_d[held_row][held_col] = held_code_q;
        end
        if (commit_go) begin
            board_d[sel_row][sel_col] = held_code_q;
            captured_d  = sel_code;
            move_done_d = 1'b1;
            side_d      = ~side_q;
            if (move_count_q != 16'hFFFF) move_count_d = move_count_q + 16'd1;
`ifdef BOARD_UNDO_EN
            undo_from_d  = held_pos_q;
            undo_to_d    = sel_pos;
            undo_moved_d = held_code_q;
            undo_cap_d   = sel_code;
            undo_ok_d    = 1'b1;
`endif
        end
`ifdef BOARD_UNDO_EN
        if (undo_go) begin
            board_d[undo_from_q[POS_W-1:CW]][undo_from_q[CW-1:0]] = undo_moved_q;
            board_d[undo_to_q[POS_W-1:CW]][undo_to_q[CW-1:0]]     = undo_cap_q;
            move_count_d = move_count_q - 16'd1;
            side_d       = ~side_q;
            undo_ok_d    = 1'b0;
        end
`endif
    end

    // Display read sees the board as it stood before this cycle's update.
    always_comb begin
        rd_code_d = '0;
        if (rd_valid) begin
            if (is_held && board_q[rd_row][rd_col] == '0 && mask_rc[rd_row][rd_col])
                rd_code_d = HILITE_CODE;
            else
                rd_code_d = board_q[rd_row][rd_col];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            board_q      <= board_rv;
            held_code_q  <= '0;
            held_pos_q   <= '0;
            captured_q   <= '0;
            move_count_q <= '0;
            side_q       <= 1'b0;
            move_done_q  <= 1'b0;
            illegal_q    <= 1'b0;
            rd_code_q    <= '0;
        end else begin
            board_q      <= board_d;
            held_code_q  <= held_code_d;
            held_pos_q   <= held_pos_d;
            captured_q   <= captured_d;
            move_count_q <= move_count_d;
            side_q       <= side_d;
            move_done_q  <= move_done_d;
            illegal_q    <= illegal_d;
            rd_code_q    <= rd_code_d;
        end
    end

`ifdef BOARD_UNDO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            undo_from_q  <= '0;
            undo_to_q    <= '0;
            undo_moved_q <= '0;
            undo_cap_q   <= '0;
            undo_ok_q    <= 1'b0;
        end else begin
            undo_from_q  <= undo_from_d;
            undo_to_q    <= undo_to_d;
            undo_moved_q <= undo_moved_d;
            undo_cap_q   <= undo_cap_d;
            undo_ok_q    <= undo_ok_d;
        end
    end
`endif

    assign board         = board_q;
    assign rd_code       = rd_code_q;
    assign held_code     = held_code_q;
    assign held_pos      = held_pos_q;
    assign move_done     = move_done_q;
    assign captured_code = captured_q;
    assign illegal       = illegal_q;
    assign move_count    = move_count_q;
    assign side          = side_q;

endmodule

`default_nettype wire
